// File: rtl/aes_decipher_block_p.sv
`default_nettype none
// ============================================================================
//  Module      : aes_decipher_block_p
//  Description : Iterative AES inverse cipher, one 128-bit block per
//                operation. InvSubBytes is spread over S = 4/SBOX_LANES
//                cycles per round. The key length is latched when an
//                operation is accepted.
//  Revision    : 1.0 - initial release
//
//  Configuration macro:
//    AES_DEC_KEY192_EN - when defined, keylen 2'b01 selects AES-192 (Nr=12).
//                        When undefined, 2'b01 decodes as AES-128.
//
//  Parameters:
//    SBOX_LANES  32-bit words substituted per cycle (1, 2 or 4)
//
//  Ports:
//    clk        in   1    clock, rising edge
//    reset_n    in   1    asynchronous active-low reset
//    next       in   1    start pulse, accepted only when idle
//    keylen     in   2    00 AES-128, 10 AES-256, 01 AES-192 (macro), 11 -> 128
//    round      out  4    round index presented to the key memory
//    round_key  in   128  round key for 'round', consumed in the same cycle
//    block      in   128  ciphertext, read in the cycle after accept
//    new_block  out  128  state register; plaintext while ready=1
//    ready      out  1    1 = idle / result valid, 0 = busy
// ============================================================================
module aes_decipher_block_p #(
    parameter int SBOX_LANES = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         next,
    input  logic [1:0]   keylen,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    input  logic [127:0] block,
    output logic [127:0] new_block,
    output logic         ready
);

    if (SBOX_LANES != 1 && SBOX_LANES != 2 && SBOX_LANES != 4) begin : g_bad_lanes
        $fatal(1, "aes_decipher_block_p: SBOX_LANES must be 1, 2 or 4");
    end

    localparam int         S_CYC    = (SBOX_LANES > 0) ? 4 / SBOX_LANES : 1;
    localparam logic [1:0] LANE_LAST = 2'(S_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_SBOX = 2'd2,
        ST_MAIN = 2'd3
    } state_e;

    // ------------------------------------------------------------------------
    // GF(2^8) helpers, polynomial 0x11b
    // ------------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // Inverse S-box: undo the affine transform, then take the multiplicative
    // inverse as a^254 (square-and-multiply; 0 maps to 0 naturally).
    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] a;
        logic [7:0] p;
        logic [7:0] r;
        a = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        p = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    // State layout: column c is word c (w0 = bits 127:96), row 0 is the
    // most significant byte of each word. Row r rotates right by r columns.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = s;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        return {inv_mix_col(s[127:96]), inv_mix_col(s[95:64]),
                inv_mix_col(s[63:32]),  inv_mix_col(s[31:0])};
    endfunction

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_e        fsm_q,   fsm_d;
    logic [127:0]  state_q, state_d;
    logic [3:0]    round_q, round_d;
    logic [3:0]    nr_q,    nr_d;
    logic [1:0]    lane_q,  lane_d;
    logic          ready_q, ready_d;

    logic [3:0]    nr_sel;
    logic [127:0]  sub_state;
    logic [127:0]  final_state;
    logic [1:0]    lane_word [SBOX_LANES];
    logic [31:0]   lane_out  [SBOX_LANES];

    // Number of rounds selected by keylen; only meaningful at accept.
    always_comb begin
        nr_sel = 4'd10;
        case (keylen)
            2'b10:   nr_sel = 4'd14;
`ifdef AES_DEC_KEY192_EN
            2'b01:   nr_sel = 4'd12;
`endif
            default: nr_sel = 4'd10;
        endcase
    end

    // One InvSubBytes word per lane; lane j of group k handles word k*L+j.
    for (genvar j = 0; j < SBOX_LANES; j++) begin : g_lane
        logic [31:0] lane_in;
        assign lane_word[j] = 2'(int'(lane_q) * SBOX_LANES + j);
        assign lane_in      = state_q[127 - 32*lane_word[j] -: 32];
        assign lane_out[j]  = {inv_sbox(lane_in[31:24]), inv_sbox(lane_in[23:16]),
                               inv_sbox(lane_in[15:8]),  inv_sbox(lane_in[7:0])};
    end

    always_comb begin
        sub_state = state_q;
        for (int j = 0; j < SBOX_LANES; j++) begin
            sub_state[127 - 32*lane_word[j] -: 32] = lane_out[j];
        end
    end

    // InvSubBytes has already been applied in the SBOX phase; the two steps
    // commute, so InvShiftRows is applied here in the MAIN cycle.
    assign final_state = inv_shift_rows(state_q) ^ round_key;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q   <= ST_IDLE;
            state_q <= '0;
            round_q <= 4'd0;
            nr_q    <= 4'd10;
            lane_q  <= 2'd0;
            ready_q <= 1'b1;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            round_q <= round_d;
            nr_q    <= nr_d;
            lane_q  <= lane_d;
            ready_q <= ready_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state and datapath
    // ------------------------------------------------------------------------
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        round_d = round_q;
        nr_d    = nr_q;
        lane_d  = lane_q;
        ready_d = ready_q;
        case (fsm_q)
            ST_IDLE: begin
                if (next) begin
                    ready_d = 1'b0;
                    round_d = 4'd0;
                    nr_d    = nr_sel;
                    fsm_d   = ST_INIT;
                end
            end
            ST_INIT: begin
                state_d = block ^ round_key;
                round_d = 4'd1;
                lane_d  = 2'd0;
                fsm_d   = ST_SBOX;
            end
            ST_SBOX: begin
                state_d = sub_state;
                if (lane_q == LANE_LAST) begin
                    lane_d = 2'd0;
                    fsm_d  = ST_MAIN;
                end else begin
                    lane_d = lane_q + 2'd1;
                end
            end
            ST_MAIN: begin
                if (round_q == nr_q) begin
                    state_d = final_state;
                    ready_d = 1'b1;
                    fsm_d   = ST_IDLE;
                end else begin
                    state_d = inv_mix_columns(final_state);
                    round_d = round_q + 4'd1;
                    fsm_d   = ST_SBOX;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    assign round     = round_q;
    assign new_block = state_q;
    assign ready     = ready_q;

endmodule
`default_nettype wire
